// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline-register chain (pipe_stage_chain and
// pipe_stage): default sizes and the per-stage {valid, data} record at the
// default payload width.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_DEF_WIDTH   = 32;
    localparam int PIPE_DEF_STAGES  = 3;
    localparam int PIPE_STALL_CNT_W = 16;

    // One stage's content at the default payload width. Stages with a
    // different WIDTH build the same record shape locally.
    typedef struct packed {
        logic                      valid;
        logic [PIPE_DEF_WIDTH-1:0] data;
    } pipe_rec_t;

endpackage

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One register stage of the chain: holds a valid bit and a payload.
// Priority per cycle: reset > flush > load > keep. A load of an invalid
// source stores an all-zero bubble, so valid=0 always implies data=0.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (clears valid and data)
//   load_i       stage advances this cycle and takes its source
//   flush_i      stage becomes a bubble (wins over load and keep)
//   src_valid_i  valid of the source offered to this stage
//   src_data_i   payload of the source offered to this stage
//   valid_o      stored valid bit
//   data_o       stored payload
// -----------------------------------------------------------------------------
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic             src_valid_i,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d = '0;
        end else if (load_i) begin
            stage_d.valid = src_valid_i;
            // Mask the payload so a bubble is always all-zero.
            stage_d.data  = src_valid_i ? src_data_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_o = stage_q.valid;
    assign data_o  = stage_q.data;

endmodule

// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
// Parametrised chain of STAGES pipeline registers carrying a WIDTH-bit payload
// with a valid bit per stage, per-stage hold and flush, a downstream ready
// handshake and a saturating stall-cycle counter.
// Build option: define PIPE_BUBBLE_COLLAPSE_EN for collapse mode (an empty
// stage accepts data even when downstream is stalled). Undefined gives classic
// mode, where any downstream stall freezes every upstream stage.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     upstream offers in_data
//   in_data      payload into stage 0
//   in_ready     stage 0 advances this cycle (combinational)
//   hold         hold[k]: stage k keeps its content
//   flush        flush[k]: stage k becomes a bubble
//   out_valid    valid of the last stage
//   out_data     payload of the last stage
//   out_ready    consumer accepts the last stage
//   stage_valid  valid bit of every stage
//   stage_data   payload of stage k at [k*WIDTH +: WIDTH]
//   occupancy    number of valid stages (combinational)
//   stall_cnt    saturating count of cycles with in_valid & ~in_ready
// -----------------------------------------------------------------------------
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH  = PIPE_DEF_WIDTH,
    parameter int STAGES = PIPE_DEF_STAGES,
    parameter int CNT_W  = PIPE_STALL_CNT_W,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       hold,
    input  logic [STAGES-1:0]       flush,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic [OCC_W-1:0]        occupancy,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic [STAGES-1:0]       adv;
    logic [STAGES-1:0]       src_valid;
    logic [STAGES*WIDTH-1:0] src_data;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;

    // Advance chain, resolved from the consumer back towards stage 0.
    // Flush is deliberately not part of it: an item moving into a flushed
    // stage is dropped but still counts as sent by its upstream stage.
    always_comb begin
        logic nxt;
        adv = '0;
        nxt = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
`ifdef PIPE_BUBBLE_COLLAPSE_EN
            adv[k] = ~hold[k] & (nxt | ~stage_valid[k]);
`else
            adv[k] = ~hold[k] & nxt;
`endif
            nxt = adv[k];
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            if (g == 0) begin : g_src_in
                assign src_valid[0]       = in_valid;
                assign src_data[0 +: WIDTH] = in_data;
            end else begin : g_src_prev
                // A held upstream stage offers a bubble (load-use stall).
                assign src_valid[g]             = stage_valid[g-1] & ~hold[g-1];
                assign src_data[g*WIDTH +: WIDTH] = stage_data[(g-1)*WIDTH +: WIDTH];
            end

            pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk         (clk),
                .rst         (rst),
                .load_i      (adv[g]),
                .flush_i     (flush[g]),
                .src_valid_i (src_valid[g]),
                .src_data_i  (src_data[g*WIDTH +: WIDTH]),
                .valid_o     (stage_valid[g]),
                .data_o      (stage_data[g*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign in_ready  = adv[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[(STAGES-1)*WIDTH +: WIDTH];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(stage_valid[k]);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && !in_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;

    localparam int W = 32;
    localparam int S = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]     in_data, out_data;
    logic [S-1:0]     hold, flush, stage_valid;
    logic [S*W-1:0]   stage_data;
    logic [1:0]       occupancy;
    logic [15:0]      stall_cnt;

    logic             s_rst, s_iv, s_ir, s_ov, s_ordy;
    logic [7:0]       s_data, s_odata;
    logic [2:0]       s_hold, s_flush, s_sv;
    logic [23:0]      s_sd;
    logic [1:0]       s_occ;
    logic [3:0]       s_cnt;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic chk_en = 1'b0;

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .hold(hold), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_chain #(.WIDTH(8), .STAGES(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_data(s_data),
        .in_ready(s_ir), .hold(s_hold), .flush(s_flush),
        .out_valid(s_ov), .out_data(s_odata), .out_ready(s_ordy),
        .stage_valid(s_sv), .stage_data(s_sd),
        .occupancy(s_occ), .stall_cnt(s_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [S-1:0]        v;
        logic [S-1:0][W-1:0] d;
        logic [15:0]         cnt;
    } mst_t;

    mst_t m = '0;

    // Which stages move this cycle.
    function automatic logic [S-1:0] m_adv(input mst_t s);
        logic [S-1:0] a;
        a = '0;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
        begin
            logic nxt;
            nxt = out_ready;
            for (int k = S - 1; k >= 0; k--) begin
                a[k] = ~hold[k] & (nxt | ~s.v[k]);
                nxt  = a[k];
            end
        end
`else
        // Classic: a stage moves only if the consumer takes and nothing at
        // or after it is held.
        for (int k = 0; k < S; k++) a[k] = out_ready & ~|(hold >> k);
`endif
        return a;
    endfunction

    function automatic mst_t m_next(input mst_t s);
        mst_t         n;
        logic [S-1:0] a;
        logic         sv;
        logic [W-1:0] sd;
        n = s;
        a = m_adv(s);
        if (rst) return '0;
        if (in_valid && !a[0] && s.cnt != 16'hFFFF) n.cnt = s.cnt + 16'd1;
        for (int k = 0; k < S; k++) begin
            if (flush[k]) begin
                n.v[k] = 1'b0;
                n.d[k] = '0;
            end else if (a[k]) begin
                if (k == 0) begin
                    sv = in_valid;
                    sd = in_data;
                end else begin
                    sv = s.v[k-1] & ~hold[k-1];
                    sd = s.d[k-1];
                end
                n.v[k] = sv;
                n.d[k] = sv ? sd : '0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) m <= m_next(m);

    always @(negedge clk) begin : chk_blk
        logic [S-1:0] ea;
        if (chk_en) begin
            ea = m_adv(m);
            check("out_valid",   out_valid,   m.v[S-1]);
            check("out_data",    out_data,    m.d[S-1]);
            check("stage_valid", stage_valid, m.v);
            check("stage_data",  stage_data,  m.d);
            check("occupancy",   occupancy,   $countones(m.v));
            check("stall_cnt",   stall_cnt,   m.cnt);
            check("in_ready",    in_ready,    ea[0]);
        end
    end

    // ---------------- directed table ----------------
    typedef struct packed {
        logic         iv;
        logic [W-1:0] d;
        logic [S-1:0] h;
        logic [S-1:0] f;
        logic         ordy;
    } vec_t;

    vec_t tbl [14] = '{
        '{1'b1, 32'h101, 3'b000, 3'b000, 1'b1},
        '{1'b1, 32'h102, 3'b000, 3'b000, 1'b1},
        '{1'b1, 32'h103, 3'b001, 3'b000, 1'b1},
        '{1'b1, 32'h104, 3'b000, 3'b000, 1'b0},
        '{1'b1, 32'h105, 3'b100, 3'b000, 1'b1},
        '{1'b0, 32'h0,   3'b000, 3'b001, 1'b1},
        '{1'b1, 32'h106, 3'b011, 3'b010, 1'b1},
        '{1'b1, 32'h107, 3'b000, 3'b000, 1'b0},
        '{1'b1, 32'h108, 3'b000, 3'b100, 1'b0},
        '{1'b0, 32'h0,   3'b000, 3'b000, 1'b1},
        '{1'b0, 32'h0,   3'b010, 3'b000, 1'b1},
        '{1'b0, 32'h0,   3'b000, 3'b000, 1'b1},
        '{1'b0, 32'h0,   3'b000, 3'b000, 1'b1},
        '{1'b0, 32'h0,   3'b000, 3'b000, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; hold = '0; flush = '0; out_ready = 1'b1;
        s_rst = 1'b1; s_iv = 1'b0; s_data = '0; s_hold = '0; s_flush = '0; s_ordy = 1'b0;
        cyc();
        cyc();
        chk_en = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_occupancy", occupancy, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rst = 1'b0;

        // 1. straight flow
        in_valid = 1'b1; in_data = 32'h11; cyc();
        in_data = 32'h22; cyc();
        in_data = 32'h33; cyc();
        check("flow_out0", {out_valid, out_data}, {1'b1, 32'h11});
        in_valid = 1'b0; in_data = '0; cyc();
        check("flow_out1", {out_valid, out_data}, {1'b1, 32'h22});
        cyc();
        check("flow_out2", {out_valid, out_data}, {1'b1, 32'h33});
        check("flow_stall", stall_cnt, 0);
        cyc();

        // 2. load-use stall on stage 1
        in_valid = 1'b1; in_data = 32'hC0C; cyc();
        in_data = 32'hB0B; cyc();
        in_data = 32'hA0A; cyc();
        check("lu_out_c", {out_valid, out_data}, {1'b1, 32'hC0C});
        in_valid = 1'b0; in_data = '0; hold = 3'b010; cyc();
        check("lu_bubble", {out_valid, out_data}, {1'b0, 32'h0});
        check("lu_a_kept", stage_data[31:0], 32'hA0A);
        hold = 3'b000; cyc();
        check("lu_out_b", {out_valid, out_data}, {1'b1, 32'hB0B});
        cyc();
        check("lu_out_a", {out_valid, out_data}, {1'b1, 32'hA0A});
        cyc();

        // 3. flush stages 1 and 2
        in_valid = 1'b1; in_data = 32'h1; cyc();
        in_data = 32'h2; cyc();
        in_data = 32'h3; cyc();
        in_data = 32'h4; flush = 3'b110; cyc();
        check("fl_valid", stage_valid, 3'b001);
        check("fl_upper_zero", stage_data[95:32], 64'h0);
        check("fl_s0", stage_data[31:0], 32'h4);
        flush = '0; in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("fl_item2_gone", (out_valid && out_data == 32'h2), 1'b0);
        end

        // 4. collapse vs classic with consumer stalled
        rst = 1'b1; cyc();
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA1; cyc();
        out_ready = 1'b0; in_data = 32'hA2; #1;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
        check("col_ir0", in_ready, 1'b1);
        cyc(); in_data = 32'hA3; #1;
        check("col_ir1", in_ready, 1'b1);
        cyc();
        check("col_ir2", {in_ready, occupancy}, {1'b0, 2'd3});
        cyc();
        check("col_stall", stall_cnt, 16'd1);
`else
        check("cls_ir0", in_ready, 1'b0);
        cyc(); in_data = 32'hA3; #1;
        check("cls_ir1", in_ready, 1'b0);
        cyc();
        check("cls_ir2", {in_ready, occupancy}, {1'b0, 2'd1});
        cyc();
        check("cls_stall", stall_cnt, 16'd3);
`endif

        // 5. reset while full and flushing
        out_ready = 1'b1; in_data = 32'hB1; cyc();
        in_data = 32'hB2; cyc();
        check("rs_full", occupancy, 2'd3);
        rst = 1'b1; flush = 3'b111; in_data = 32'hB3; out_ready = 1'b0; cyc();
        check("rs_valid", stage_valid, 3'b000);
        check("rs_stall", stall_cnt, 16'd0);
        check("rs_out_data", out_data, 32'h0);
        check("rs_occ", occupancy, 2'd0);
        rst = 1'b0; flush = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cyc();

        // mixed hold / flush / ready table, checked against the model
        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; in_data = tbl[i].d; hold = tbl[i].h;
            flush = tbl[i].f; out_ready = tbl[i].ordy;
            cyc();
        end
        in_valid = 1'b0; in_data = '0; hold = '0; flush = '0; out_ready = 1'b1;
        cyc();

        // 6. stall counter saturation at CNT_W=4
        s_rst = 1'b1; cyc();
        s_rst = 1'b0; s_iv = 1'b1; s_data = 8'h5A; s_ordy = 1'b0;
        repeat (5) cyc();
`ifdef PIPE_BUBBLE_COLLAPSE_EN
        check("sat_5", s_cnt, 4'd2);
`else
        check("sat_5", s_cnt, 4'd5);
`endif
        repeat (15) cyc();
        check("sat_final", s_cnt, 4'hF);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
